// File: rtl/line_buf_arbiter.sv
// Line-buffer RAM arbiter: two requesters share one single-port RAM using
// round-robin burst ownership, an atomic-sequence lock and a fairness limit.
module line_buf_arbiter #(
   parameter int  WIDTH     = 8,
   parameter int  LEN       = 256,
   parameter int  MAX_BURST = 16,
   localparam int AW        = $clog2(LEN)
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             a_req,
   input  logic             a_lock,
   input  logic             a_we,
   input  logic [AW-1:0]    a_addr,
   input  logic [WIDTH-1:0] a_wdata,
   output logic             a_gnt,
   output logic             a_rvalid,
   output logic [WIDTH-1:0] a_rdata,

   input  logic             b_req,
   input  logic             b_lock,
   input  logic             b_we,
   input  logic [AW-1:0]    b_addr,
   input  logic [WIDTH-1:0] b_wdata,
   output logic             b_gnt,
   output logic             b_rvalid,
   output logic [WIDTH-1:0] b_rdata,

   output logic [AW-1:0]    mem_addr,
   output logic [WIDTH-1:0] mem_din,
   output logic             mem_we,
   input  logic [WIDTH-1:0] mem_dout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   localparam logic       LAST_A    = 1'b0;
   localparam logic       LAST_B    = 1'b1;
   localparam logic [8:0] BURST_LIM = 9'(MAX_BURST);

   state_t           state;
   state_t           state_next;
   logic             last;
   logic [7:0]       bcnt;
   logic             acc_a;
   logic             acc_b;
   logic             acc_own;
   logic             want_a;
   logic             want_b;
   logic [8:0]       bsum;
   logic             burst_hit;
   logic [WIDTH-1:0] a_hold;
   logic [WIDTH-1:0] b_hold;

   assign a_gnt   = (state == OWN_A);
   assign b_gnt   = (state == OWN_B);
   assign acc_a   = a_req & a_gnt;
   assign acc_b   = b_req & b_gnt;
   assign acc_own = acc_a | acc_b;
   assign want_a  = a_req | a_lock;
   assign want_b  = b_req | b_lock;

   // The access in the current cycle counts toward the limit, so the owner
   // hands over right after its MAX_BURST-th access.
   assign bsum      = {1'b0, bcnt} + {8'd0, acc_own};
   assign burst_hit = (bsum >= BURST_LIM);

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (want_a && want_b) begin
               state_next = (last == LAST_B) ? OWN_A : OWN_B;
            end else if (want_a) begin
               state_next = OWN_A;
            end else if (want_b) begin
               state_next = OWN_B;
            end
         end
         OWN_A: begin
            if (!a_lock) begin
               if (want_b && (!a_req || burst_hit)) begin
                  state_next = OWN_B;
               end else if (!a_req && !want_b) begin
                  state_next = IDLE;
               end
            end
         end
         OWN_B: begin
            if (!b_lock) begin
               if (want_a && (!b_req || burst_hit)) begin
                  state_next = OWN_A;
               end else if (!b_req && !want_a) begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         last  <= LAST_B;
         bcnt  <= 8'd0;
      end else begin
         state <= state_next;
         if (state_next != state && state_next == OWN_A) begin
            last <= LAST_A;
            bcnt <= 8'd0;
         end else if (state_next != state && state_next == OWN_B) begin
            last <= LAST_B;
            bcnt <= 8'd0;
         end else if (acc_own && bcnt != 8'hFF) begin
            bcnt <= bcnt + 8'd1;
         end
      end
   end

   always_comb begin
      mem_addr = '0;
      mem_din  = '0;
      mem_we   = 1'b0;
      case (state)
         OWN_A: begin
            mem_addr = a_addr;
            mem_din  = a_wdata;
            mem_we   = a_we & acc_a;
         end
         OWN_B: begin
            mem_addr = b_addr;
            mem_din  = b_wdata;
            mem_we   = b_we & acc_b;
         end
         default: ;
      endcase
   end

   // Read data is passed straight through while valid and held afterwards,
   // so the requester can sample it late without the RAM output changing.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         a_hold   <= '0;
         b_hold   <= '0;
      end else begin
         a_rvalid <= acc_a & ~a_we;
         b_rvalid <= acc_b & ~b_we;
         if (a_rvalid) a_hold <= mem_dout;
         if (b_rvalid) b_hold <= mem_dout;
      end
   end

   assign a_rdata = a_rvalid ? mem_dout : a_hold;
   assign b_rdata = b_rvalid ? mem_dout : b_hold;

endmodule
